// File: rtl/edge_window_sequencer.sv
// Line-buffered 3x3 window generator for the edge detectors. Pixels arrive in
// raster order; two line buffers hold the previous two rows so that each
// accepted pixel completes a new right-hand column of the window. A small FSM
// tracks frame progress so that only windows lying fully inside the frame are
// flagged valid.
module edge_window_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic          clock,
    input  logic          iReset_n,
    input  logic [9:0]    iPixel,
    input  logic          iValid,
    input  logic          iSOF,
    output logic [89:0]   oGrid,
    output logic          oGridValid,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oEOF,
    output logic          oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] XTWO  = XW'(2);
    localparam logic [YW-1:0] YTWO  = YW'(2);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [89:0]   win_q, win_d;
    logic          gridValid_q, gridValid_d;
    logic          eof_q, eof_d;
    logic [XW-1:0] oX_q, oX_d;
    logic [YW-1:0] oY_q, oY_d;

    logic          accept;
    logic [XW-1:0] curX;
    logic [YW-1:0] curY;

    // lineA holds the row above the current one, lineB the row above that
    logic [9:0] lineA [WIDTH];
    logic [9:0] lineB [WIDTH];

    // Acceptance, window shift, counter advance, frame FSM and output staging
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        win_d       = win_q;
        gridValid_d = 1'b0;
        eof_d       = 1'b0;
        oX_d        = oX_q;
        oY_d        = oY_q;

        accept = iValid && (iSOF || (state_q == FILL) || (state_q == RUN));
        curX   = iSOF ? '0 : x_q;
        curY   = iSOF ? '0 : y_q;

        if (accept) begin
            win_d = {win_q[79:60], lineB[curX],
                     win_q[49:30], lineA[curX],
                     win_q[19:0],  iPixel};

            if (curX == XLAST) begin
                x_d = '0;
                y_d = curY + YW'(1);
            end else begin
                x_d = curX + XW'(1);
                y_d = curY;
            end

            gridValid_d = (state_q == RUN) && !iSOF && (curX >= XTWO);
            oX_d        = curX - XW'(1);
            oY_d        = curY - YW'(1);

            if (iSOF) begin
                state_d = FILL;
            end else if ((state_q == FILL) && (curX == '0) && (curY == YTWO)) begin
                state_d = RUN;
            end else if ((state_q == RUN) && (curX == XLAST) && (curY == YLAST)) begin
                state_d = DONE;
                eof_d   = 1'b1;
                x_d     = '0;
                y_d     = '0;
            end
        end
    end

    // Control state, window and output registers with asynchronous reset
    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            win_q       <= '0;
            gridValid_q <= 1'b0;
            eof_q       <= 1'b0;
            oX_q        <= '0;
            oY_q        <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_q       <= win_d;
            gridValid_q <= gridValid_d;
            eof_q       <= eof_d;
            oX_q        <= oX_d;
            oY_q        <= oY_d;
        end
    end

    // Line buffers need no reset: they are always refilled before being read out
    always_ff @(posedge clock) begin
        if (accept) begin
            lineB[curX] <= lineA[curX];
            lineA[curX] <= iPixel;
        end
    end

    assign oGrid      = win_q;
    assign oGridValid = gridValid_q;
    assign oX         = oX_q;
    assign oY         = oY_q;
    assign oEOF       = eof_q;
    assign oBusy      = (state_q == FILL) || (state_q == RUN);

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Self-checking bench for edge_window_sequencer on a small 8x6 frame. The
// reference model stores the frame as a 2D image and derives every expected
// window directly from image coordinates.
module tb_edge_window_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 3;
    localparam int YW = 3;

    logic          clock = 1'b0;
    logic          iReset_n;
    logic [9:0]    iPixel;
    logic          iValid;
    logic          iSOF;
    logic [89:0]   oGrid;
    logic          oGridValid;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic          oEOF;
    logic          oBusy;

    edge_window_sequencer #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
        .clock      (clock),
        .iReset_n   (iReset_n),
        .iPixel     (iPixel),
        .iValid     (iValid),
        .iSOF       (iSOF),
        .oGrid      (oGrid),
        .oGridValid (oGridValid),
        .oX         (oX),
        .oY         (oY),
        .oEOF       (oEOF),
        .oBusy      (oBusy)
    );

    // Free-running 10-time-unit clock
    always #5 clock = ~clock;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: the frame image and the raster position
    logic [9:0]  img [H][W];
    bit          inFrame = 1'b0;
    int          mx = 0;
    int          my = 0;
    bit          expGV, expEOF, expBusy;
    logic [89:0] expGrid;
    int          expX, expY;

    // Observation bookkeeping
    int          gridCount = 0;
    int          eofCount  = 0;
    int          eofX, eofY;
    bit          eofWithGV;
    int          capIdx = -1;
    logic [89:0] capGrid;
    int          capX, capY;
    int          firstVals [9];

    task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("gridValid", 90'(oGridValid), 90'(expGV));
        check("eof", 90'(oEOF), 90'(expEOF));
        check("busy", 90'(oBusy), 90'(expBusy));
        if (expGV) begin
            check("grid", oGrid, expGrid);
            check("oX", 90'(oX), 90'(expX));
            check("oY", 90'(oY), 90'(expY));
        end
        if (oGridValid) begin
            if (gridCount == capIdx) begin
                capGrid = oGrid;
                capX    = int'(oX);
                capY    = int'(oY);
            end
            gridCount++;
        end
        if (oEOF) begin
            eofCount++;
            eofX      = int'(oX);
            eofY      = int'(oY);
            eofWithGV = oGridValid;
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, check after the edge
    task automatic applyStimulus(input bit v, input bit s, input logic [9:0] p);
        iValid = v;
        iSOF   = s;
        iPixel = p;
        expGV  = 1'b0;
        expEOF = 1'b0;
        if (v && (s || inFrame)) begin
            if (s) begin
                mx      = 0;
                my      = 0;
                inFrame = 1'b1;
            end
            img[my][mx] = p;
            if (my >= 2 && mx >= 2) begin
                expGV = 1'b1;
                for (int k = 0; k < 9; k++)
                    expGrid[10*k +: 10] = img[my - k/3][mx - k%3];
                expX = mx - 1;
                expY = my - 1;
            end
            if (mx == W-1 && my == H-1) begin
                expEOF  = 1'b1;
                inFrame = 1'b0;
            end
            if (mx == W-1) begin
                mx = 0;
                my++;
            end else begin
                mx++;
            end
        end
        expBusy = inFrame;
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    // valMode: 0 continuous, 1 valid/idle alternating, 2 random gaps.
    // pixMode: 0 value = base + 8*y + x, 1 random. stopAt: raster index to stop at (-1 = full).
    task automatic runFrame(input int valMode, input int pixMode, input int base, input int stopAt);
        for (int idx = 0; idx < W*H; idx++) begin
            logic [9:0] p;
            if (idx == stopAt) break;
            if (pixMode == 0) p = 10'(base + 8*(idx / W) + (idx % W));
            else              p = 10'($urandom_range(0, 1023));
            if (valMode == 2 && $urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
            applyStimulus(1'b1, idx == 0, p);
            if (valMode == 1)
                applyStimulus(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_grid"}, oGrid, 90'(0));
        check({tag, "_gv"}, 90'(oGridValid), 90'(0));
        check({tag, "_x"}, 90'(oX), 90'(0));
        check({tag, "_y"}, 90'(oY), 90'(0));
        check({tag, "_eof"}, 90'(oEOF), 90'(0));
        check({tag, "_busy"}, 90'(oBusy), 90'(0));
    endtask

    task automatic checkFirstGrid(input string tag, input int base);
        logic [89:0] e;
        for (int k = 0; k < 9; k++) e[10*k +: 10] = 10'(firstVals[k] + base);
        check({tag, "_firstGrid"}, capGrid, e);
        check({tag, "_firstX"}, 90'(capX), 90'(1));
        check({tag, "_firstY"}, 90'(capY), 90'(1));
    endtask

    initial begin
        int g0, e0;
        firstVals = '{18, 17, 16, 10, 9, 8, 2, 1, 0};
        iReset_n = 1'b0;
        iValid   = 1'b0;
        iSOF     = 1'b0;
        iPixel   = '0;
        #12;
        checkAllZero("reset");
        @(negedge clock);
        iReset_n = 1'b1;
        @(posedge clock);
        #1;

        // Pixels without SOF are ignored
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 10'($urandom_range(0, 1023)));
        check("ignored_busy", 90'(oBusy), 90'(0));

        // Continuous frame, value = 8*y+x
        g0 = gridCount; e0 = eofCount; capIdx = gridCount;
        runFrame(0, 0, 0, -1);
        applyStimulus(1'b0, 1'b0, '0);
        check("contCount", 90'(gridCount - g0), 90'(24));
        check("contEofCount", 90'(eofCount - e0), 90'(1));
        check("contEofX", 90'(eofX), 90'(6));
        check("contEofY", 90'(eofY), 90'(4));
        check("contEofWithGV", 90'(eofWithGV), 90'(1));
        checkFirstGrid("cont", 0);

        // Alternating valid
        g0 = gridCount; capIdx = gridCount;
        runFrame(1, 0, 0, -1);
        applyStimulus(1'b0, 1'b0, '0);
        check("toggleCount", 90'(gridCount - g0), 90'(24));
        checkFirstGrid("toggle", 0);

        // Truncated frame at (3,4), then a full random-valued frame
        e0 = eofCount;
        runFrame(0, 1, 0, 4*W + 3);
        check("truncNoEof", 90'(eofCount - e0), 90'(0));
        g0 = gridCount;
        runFrame(0, 1, 0, -1);
        applyStimulus(1'b0, 1'b0, '0);
        check("afterTruncCount", 90'(gridCount - g0), 90'(24));
        check("afterTruncEof", 90'(eofCount - e0), 90'(1));

        // Reset pulse at (5,3)
        runFrame(0, 0, 0, 3*W + 5);
        iValid = 1'b0;
        iSOF   = 1'b0;
        #2;
        iReset_n = 1'b0;
        #1;
        checkAllZero("midReset");
        inFrame = 1'b0;
        @(negedge clock);
        iReset_n = 1'b1;
        @(posedge clock);
        #1;
        g0 = gridCount; capIdx = gridCount;
        runFrame(2, 0, 0, -1);
        applyStimulus(1'b0, 1'b0, '0);
        check("afterResetCount", 90'(gridCount - g0), 90'(24));
        checkFirstGrid("afterReset", 0);

        // Back-to-back frames, second offset by +100
        g0 = gridCount; capIdx = gridCount + 24;
        runFrame(0, 0, 0, -1);
        runFrame(0, 0, 100, -1);
        applyStimulus(1'b0, 1'b0, '0);
        check("b2bCount", 90'(gridCount - g0), 90'(48));
        checkFirstGrid("b2bSecond", 100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/edge_window_sequencer.md
Name: edge_window_sequencer

Overview:
- Streams raster-order 10-bit intensity pixels into two internal line buffers.
- Assembles the 3x3 neighbourhood as a 90-bit grid for the downstream horizontal/vertical edge detectors.
- Sequences frame start/fill/run/done so detectors only see windows fully inside the frame.
- Sits between the grayscale conversion stage and the edge detectors; emits the centre-pixel coordinates alongside each grid.

Parameters:
- WIDTH, 640, active pixels per line (>=3).
- HEIGHT, 480, active lines per frame (>=3).
- XW, 10, column counter width (must cover WIDTH-1).
- YW, 9, row counter width (must cover HEIGHT-1).

Ports:
- clock  in  1  single system clock; all state on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iPixel  in  10  incoming intensity.
- iValid  in  1  iPixel accepted this cycle when high; no backpressure.
- iSOF  in  1  qualified by iValid; marks pixel (0,0) of a new frame.
- oGrid  out  90  window; [10k+9:10k] = slot k. Slots 8,7,6 = oldest row (y-2); 5,4,3 = middle row; 2,1,0 = current row (y). Within a row the higher slot is the older (left) column.
- oGridValid  out  1  oGrid/oX/oY valid this cycle.
- oX  out  XW  centre column of oGrid (x-1).
- oY  out  YW  centre row of oGrid (y-1).
- oEOF  out  1  one-cycle pulse: last pixel (WIDTH-1,HEIGHT-1) accepted.
- oBusy  out  1  high in FILL or RUN.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Line-buffer contents are don't-care (never exposed before refilled).
- States:
  - IDLE: wait for iValid&iSOF -> FILL with that pixel as (0,0).
  - FILL: rows 0-1; no grids emitted. Transition to RUN on acceptance of pixel (0,2).
  - RUN: rows 2..HEIGHT-1. On acceptance of (WIDTH-1,HEIGHT-1): pulse oEOF and go to DONE.
  - DONE: same as IDLE, but counts as frame complete.
- iValid without iSOF in IDLE/DONE is ignored (no counter, buffer or output change).
- Per accepted pixel at column x, row y:
  - Window shifts one column left: new right column = {lineB[x], lineA[x], iPixel} into slots {6,3,0}; old slots 6,3,0 move to 7,4,1; 7,4,1 move to 8,5,2.
  - Buffer writes: lineB[x] <= lineA[x]; lineA[x] <= iPixel.
  - x increments and wraps to 0 at WIDTH-1, at which point y increments.
- Window is not cleared at line start. Windows straddling lines are suppressed by the valid rule, never emitted.
- oGridValid is registered high the cycle after acceptance iff state is RUN and x>=2. Latency is 1 cycle. oX = x-1 and oY = y-1 of the accepted pixel.
  - Exactly (WIDTH-2)*(HEIGHT-2) grids per frame.
- iSOF with iValid in FILL or RUN (truncated frame): abort the current frame, no oEOF. The pixel becomes (0,0) of the new frame; state -> FILL; no grid emitted for it.
- iValid low: no state, buffer or window change; oGridValid and oEOF deassert the next cycle.
- oEOF and the final oGridValid (centre WIDTH-2,HEIGHT-2) assert in the same cycle.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0; next frame requires iSOF.
- No arithmetic on pixel data; sums and thresholds belong to the detectors.

Test Plan:
- WIDTH=8, HEIGHT=6; frame where pixel value = 8*y+x, iValid every cycle:
  - exactly 24 grids.
  - first grid at centre (1,1) with slots 8..0 = 0,1,2,8,9,10,16,17,18.
  - oEOF coincides with last grid (oX=6, oY=4).
- Same frame with iValid toggling 1,0,1,0: identical grid sequence and count; oGridValid never high two consecutive cycles.
- Pixels with iValid=1, iSOF=0 after reset: no output, oBusy=0. Then iSOF: oBusy=1 the next cycle.
- iSOF re-asserted at (3,4) mid-frame: no oEOF; counters restart; the following full frame yields 24 grids with correct values.
- iReset_n pulsed low at (5,3): all outputs 0 asynchronously; a subsequent full frame is correct, with first grid at (1,1).
- Two back-to-back frames with no gap (second iSOF right after the first frame's last pixel): 48 grids total. The second frame's first grid contains no first-frame data, checked with values offset +100.
